// File: rtl/pll_drp_reconfig_if.sv
// Register-update stream feeding the PLL DRP reconfiguration engine.
// One entry per DRP register: address, keep-mask, replacement data, end-of-sequence flag.
`timescale 1ns/1ps
interface pll_drp_reconfig_if;
    logic        valid;
    logic        ready;
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic        last;

    modport master (output valid, addr, mask, data, last, input ready);
    modport slave  (input valid, addr, mask, data, last, output ready);
endinterface

// File: rtl/pll_drp_reconfig.sv
// DRP initiator: read-modify-write of PLL registers while the PLL is held in reset,
// then release reset and wait (bounded) for LOCKED.
`timescale 1ns/1ps
module pll_drp_reconfig #(
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pll_drp_reconfig_if.slave cmd,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [6:0]        drp_daddr,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [15:0]       drp_di,
    input  logic [15:0]       drp_do,
    input  logic              drp_drdy,
    output logic              pll_rst,
    input  logic              pll_locked
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_HOLD, ST_READ, ST_WAIT_RD, ST_WRITE, ST_WAIT_WR,
        ST_NEXT, ST_RELEASE, ST_WAIT_LOCK, ST_DONE, ST_ABORT
    } state_t;

    // Counters are loaded with N-1 so a wait state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DRDY_LD = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      mask_reg, mask_next;
    logic [15:0]      data_reg, data_next;
    logic             last_reg, last_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;
    logic [1:0]       code_reg, code_next;
    logic [6:0]       daddr_reg, daddr_next;
    logic             den_reg, den_next;
    logic             dwe_reg, dwe_next;
    logic [15:0]      di_reg, di_next;
    logic             pll_rst_reg, pll_rst_next;

    logic accept;
    logic cnt_zero;

    assign accept   = cmd.valid & ready_reg;
    assign cnt_zero = (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            mask_reg    <= '0;
            data_reg    <= '0;
            last_reg    <= 1'b0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            code_reg    <= 2'd0;
            daddr_reg   <= '0;
            den_reg     <= 1'b0;
            dwe_reg     <= 1'b0;
            di_reg      <= '0;
            pll_rst_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mask_reg    <= mask_next;
            data_reg    <= data_next;
            last_reg    <= last_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
            code_reg    <= code_next;
            daddr_reg   <= daddr_next;
            den_reg     <= den_next;
            dwe_reg     <= dwe_next;
            di_reg      <= di_next;
            pll_rst_reg <= pll_rst_next;
        end
    end

    // A drdy coinciding with counter expiry wins over the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (accept) state_next = ST_HOLD;
            ST_HOLD:      if (cnt_zero) state_next = ST_READ;
            ST_READ:      state_next = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (drp_drdy)      state_next = ST_WRITE;
                else if (cnt_zero) state_next = ST_ABORT;
            end
            ST_WRITE:     state_next = ST_WAIT_WR;
            ST_WAIT_WR: begin
                if (drp_drdy)      state_next = last_reg ? ST_RELEASE : ST_NEXT;
                else if (cnt_zero) state_next = ST_ABORT;
            end
            ST_NEXT:      if (accept) state_next = ST_READ;
            ST_RELEASE:   state_next = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (pll_locked)    state_next = ST_DONE;
                else if (cnt_zero) state_next = ST_IDLE;
            end
            ST_DONE:      state_next = ST_IDLE;
            ST_ABORT:     state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with state_reg.
    always_comb begin
        cnt_next   = cnt_zero ? cnt_reg : cnt_reg - CNT_ONE;
        mask_next  = mask_reg;
        data_next  = data_reg;
        last_next  = last_reg;
        daddr_next = daddr_reg;
        di_next    = di_reg;
        error_next = error_reg;
        code_next  = code_reg;

        if (accept) begin
            mask_next  = cmd.mask;
            data_next  = cmd.data;
            last_next  = cmd.last;
            daddr_next = cmd.addr;
        end
        if (state_reg == ST_IDLE && accept) begin
            error_next = 1'b0;
            code_next  = 2'd0;
            cnt_next   = HOLD_LD;
        end
        if (state_reg == ST_READ || state_reg == ST_WRITE) cnt_next = DRDY_LD;
        if (state_reg == ST_RELEASE) cnt_next = LOCK_LD;
        if (state_reg == ST_WAIT_RD && drp_drdy)
            di_next = (drp_do & mask_reg) | (data_reg & ~mask_reg);
        if (state_next == ST_ABORT) begin
            error_next = 1'b1;
            code_next  = 2'd1;
        end
        if (state_reg == ST_WAIT_LOCK && state_next == ST_IDLE) begin
            error_next = 1'b1;
            code_next  = 2'd2;
        end

        ready_next   = (state_next == ST_IDLE) || (state_next == ST_NEXT);
        busy_next    = (state_next != ST_IDLE);
        done_next    = (state_next == ST_DONE);
        den_next     = (state_next == ST_READ) || (state_next == ST_WRITE);
        dwe_next     = (state_next == ST_WRITE);
        pll_rst_next = state_next inside {ST_HOLD, ST_READ, ST_WAIT_RD,
                                          ST_WRITE, ST_WAIT_WR, ST_NEXT};
    end

    assign cmd.ready = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;
    assign err_code  = code_reg;
    assign drp_daddr = daddr_reg;
    assign drp_den   = den_reg;
    assign drp_dwe   = dwe_reg;
    assign drp_di    = di_reg;
    assign pll_rst   = pll_rst_reg;

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig: DRP responder + PLL lock model, transaction
// scoreboard of expected reads/writes, and per-cycle protocol checks.
`timescale 1ns/1ps
module tb_pll_drp_reconfig;
    localparam int RST_HOLD     = 4;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TIMEOUT = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_drp_reconfig_if cmd();
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0;
    logic        drp_drdy = 1'b0;
    logic        pll_rst;
    logic        pll_locked = 1'b0;

    pll_drp_reconfig #(
        .RST_HOLD(RST_HOLD), .DRDY_TIMEOUT(DRDY_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .pll_rst(pll_rst), .pll_locked(pll_locked)
    );

    typedef struct {
        logic        we;
        logic [6:0]  a;
        logic [15:0] d;
    } op_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    op_t exp_q[$];
    logic [15:0] pll_mem [128];
    logic [15:0] ref_mem [128];

    int         rsp_lat    = 2;
    logic       drop_en    = 1'b0;
    logic [6:0] drop_addr  = 7'h0;
    logic       force_drdy = 1'b0;
    logic       lock_en    = 1'b1;
    logic       stale_lock = 1'b0;
    int         pend       = 0;
    logic       pend_rd    = 1'b0;
    logic [6:0] pend_addr  = 7'h0;
    int         lock_ctr   = 0;

    logic den_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0, rst_prev = 1'b0;
    logic outstanding = 1'b0, first_acc = 1'b0;
    int rst_run = 0, n_rd = 0, n_wr = 0, n_done = 0, n_rst_rise = 0;
    int den_cyc = 0, err_rise_cyc = 0, rst_fall_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_wr(input logic [15:0] old, input logic [15:0] m,
                                             input logic [15:0] d);
        return (old & m) | (d & ~m);
    endfunction

    // Monitor (uses drdy of the previous cycle), then responder and PLL lock model.
    always @(negedge clk) begin
        op_t op;
        cyc++;
        if (!rst_n) begin
            chk("den_in_reset", {31'b0, drp_den}, 0);
            pend = 0; outstanding = 0; first_acc = 0; rst_run = 0;
            den_prev = 0; done_prev = 0; err_prev = 0; rst_prev = 0;
            drp_drdy = 0; pll_locked = 0; lock_ctr = 0;
        end else begin
            if (drp_drdy || !busy) outstanding = 0;
            if (outstanding) chk("ready_during_access", {31'b0, cmd.ready}, 0);
            if (drp_dwe) chk("dwe_with_den", {31'b0, drp_den}, 1);
            if (drp_den) begin
                chk("den_gap", {31'b0, den_prev}, 0);
                chk("den_under_rst", {31'b0, pll_rst}, 1);
                chk("ready_at_den", {31'b0, cmd.ready}, 0);
                if (first_acc) begin
                    chk("hold_len", rst_run, RST_HOLD);
                    first_acc = 0;
                end
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_den: actual addr=%0h we=%0b required none", drp_daddr, drp_dwe);
                end else begin
                    op = exp_q.pop_front();
                    chk("op_we", {31'b0, drp_dwe}, {31'b0, op.we});
                    chk("op_addr", {25'b0, drp_daddr}, {25'b0, op.a});
                    if (op.we) chk("op_di", {16'b0, drp_di}, {16'b0, op.d});
                end
                if (drp_dwe) n_wr++;
                else begin n_rd++; den_cyc = cyc; end
                outstanding = 1;
            end
            if (done) begin
                chk("done_width", {31'b0, done_prev}, 0);
                n_done++;
            end
            if (pll_rst && !rst_prev) begin n_rst_rise++; first_acc = 1; rst_run = 0; end
            if (!pll_rst && rst_prev) rst_fall_cyc = cyc;
            if (error && !err_prev) err_rise_cyc = cyc;
            if (pll_rst) rst_run++;
            den_prev = drp_den; done_prev = done; err_prev = error; rst_prev = pll_rst;

            drp_drdy = force_drdy;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp_drdy = 1;
                    drp_do = pend_rd ? pll_mem[pend_addr] : 16'h0;
                end
            end
            if (drp_den) begin
                if (drp_dwe) pll_mem[drp_daddr] = drp_di;
                if (!(drop_en && !drp_dwe && drp_daddr == drop_addr)) begin
                    pend = rsp_lat; pend_rd = !drp_dwe; pend_addr = drp_daddr;
                end
            end
            if (pll_rst) begin
                lock_ctr = 0; pll_locked = stale_lock;
            end else if (lock_en) begin
                if (lock_ctr < 3) lock_ctr++;
                pll_locked = (lock_ctr >= 3);
            end else begin
                pll_locked = 0;
            end
        end
    end

    task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                        input logic last, input logic expect_wr);
        op_t op;
        int n;
        op.we = 0; op.a = a; op.d = 16'h0;
        exp_q.push_back(op);
        if (expect_wr) begin
            op.we = 1; op.d = model_wr(ref_mem[a], m, d);
            ref_mem[a] = op.d;
            exp_q.push_back(op);
        end
        @(negedge clk);
        cmd.valid = 1; cmd.addr = a; cmd.mask = m; cmd.data = d; cmd.last = last;
        n = 0;
        while (!cmd.ready && n < 5000) begin @(negedge clk); n++; end
        chk("cmd_accepted", {31'b0, cmd.ready}, 1);
        @(posedge clk); #1;
        cmd.valid = 0;
    endtask

    task automatic wait_end(input int bound);
        int n;
        n = 0;
        while (!(done || error) && n < bound) begin @(negedge clk); n++; end
    endtask

    task automatic seq_checks(input string p, input int rd0, input int wr0, input int dn0,
                              input int rr0, input int erd, input int ewr, input int edn);
        repeat (3) @(negedge clk);
        chk({p, "_reads"}, n_rd - rd0, erd);
        chk({p, "_writes"}, n_wr - wr0, ewr);
        chk({p, "_dones"}, n_done - dn0, edn);
        chk({p, "_rst_rises"}, n_rst_rise - rr0, 1);
        chk({p, "_busy"}, {31'b0, busy}, 0);
        chk({p, "_pll_rst"}, {31'b0, pll_rst}, 0);
        chk({p, "_queue"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_ready"}, {31'b0, cmd.ready}, 1);
        chk({p, "_busy"}, {31'b0, busy}, 0);
        chk({p, "_done"}, {31'b0, done}, 0);
        chk({p, "_error"}, {31'b0, error}, 0);
        chk({p, "_code"}, {30'b0, err_code}, 0);
        chk({p, "_den"}, {31'b0, drp_den}, 0);
        chk({p, "_dwe"}, {31'b0, drp_dwe}, 0);
        chk({p, "_pll_rst"}, {31'b0, pll_rst}, 0);
        chk({p, "_daddr"}, {25'b0, drp_daddr}, 0);
        chk({p, "_di"}, {16'b0, drp_di}, 0);
    endtask

    initial begin
        int rd0, wr0, dn0, rr0, n;
        for (int i = 0; i < 128; i++) begin
            pll_mem[i] = 16'hA5A5 ^ 16'(i * 16'h0111);
        end
        pll_mem[8] = 16'hF3C7;
        for (int i = 0; i < 128; i++) ref_mem[i] = pll_mem[i];
        cmd.valid = 0; cmd.addr = 0; cmd.mask = 0; cmd.data = 0; cmd.last = 0;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #2 rst_n = 1;
        chk("model_pin1", {16'b0, model_wr(16'hF3C7, 16'h1000, 16'h0041)}, 32'h1041);
        chk("model_pin2", {16'b0, model_wr(16'h00FF, 16'hF0F0, 16'h1234)}, 32'h02F4);

        // single entry
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; rr0 = n_rst_rise;
        send(7'h08, 16'h1000, 16'h0041, 1, 1);
        wait_end(400);
        chk("s1_done", {31'b0, done}, 1);
        chk("s1_error", {31'b0, error}, 0);
        seq_checks("s1", rd0, wr0, dn0, rr0, 1, 1, 1);
        chk("s1_mem", {16'b0, pll_mem[8]}, 32'h1041);

        // three entries with idle gaps between them
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; rr0 = n_rst_rise;
        send(7'h08, 16'hFF00, 16'h00AA, 0, 1);
        repeat (10) @(negedge clk);
        send(7'h09, 16'h0F0F, 16'h5050, 0, 1);
        repeat (10) @(negedge clk);
        send(7'h14, 16'h0000, 16'hBEEF, 1, 1);
        wait_end(3000);
        chk("s2_done", {31'b0, done}, 1);
        seq_checks("s2", rd0, wr0, dn0, rr0, 3, 3, 1);
        chk("s2_mem08", {16'b0, pll_mem[8]}, 32'h10AA);
        chk("s2_mem14", {16'b0, pll_mem[20]}, 32'hBEEF);

        // read of 0x14 never answered
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; rr0 = n_rst_rise;
        drop_en = 1; drop_addr = 7'h14;
        send(7'h14, 16'hFFFF, 16'h0000, 1, 0);
        wait_end(400);
        seq_checks("s3", rd0, wr0, dn0, rr0, 1, 0, 0);
        chk("s3_error", {31'b0, error}, 1);
        chk("s3_code", {30'b0, err_code}, 1);
        chk("s3_abort_lat", err_rise_cyc - den_cyc, DRDY_TIMEOUT + 1);
        drop_en = 0;

        // drdy exactly at timeout expiry is a success
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; rr0 = n_rst_rise;
        rsp_lat = DRDY_TIMEOUT;
        send(7'h09, 16'h0000, 16'h1357, 1, 1);
        chk("s3b_err_clr", {31'b0, error}, 0);
        wait_end(1000);
        chk("s3b_done", {31'b0, done}, 1);
        seq_checks("s3b", rd0, wr0, dn0, rr0, 1, 1, 1);
        rsp_lat = 2;

        // PLL never locks
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; rr0 = n_rst_rise;
        lock_en = 0;
        send(7'h14, 16'hFF00, 16'h0012, 1, 1);
        wait_end(LOCK_TIMEOUT + 500);
        seq_checks("s4", rd0, wr0, dn0, rr0, 1, 1, 0);
        chk("s4_error", {31'b0, error}, 1);
        chk("s4_code", {30'b0, err_code}, 2);
        chk("s4_lock_lat", err_rise_cyc - rst_fall_cyc, LOCK_TIMEOUT + 1);
        lock_en = 1;

        // spurious drdy in IDLE and HOLD, stale LOCKED during reset
        @(posedge clk); #1 force_drdy = 1;
        @(posedge clk); #1 force_drdy = 0;
        @(negedge clk);
        chk("s5_idle_busy", {31'b0, busy}, 0);
        chk("s5_idle_ready", {31'b0, cmd.ready}, 1);
        chk("s5_err_sticky", {31'b0, error}, 1);
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; rr0 = n_rst_rise;
        stale_lock = 1;
        send(7'h08, 16'h00FF, 16'hCD00, 1, 1);
        chk("s5_err_clr", {31'b0, error}, 0);
        chk("s5_code_clr", {30'b0, err_code}, 0);
        force_drdy = 1;
        @(posedge clk); #1 force_drdy = 0;
        wait_end(400);
        stale_lock = 0;
        chk("s5_done", {31'b0, done}, 1);
        seq_checks("s5", rd0, wr0, dn0, rr0, 1, 1, 1);
        chk("s5_mem", {16'b0, pll_mem[8]}, 32'hCDAA);

        // asynchronous reset while waiting for the write response
        rsp_lat = 6;
        send(7'h09, 16'hFFF0, 16'h000C, 1, 1);
        n = 0;
        while (!(drp_den && drp_dwe) && n < 400) begin @(negedge clk); n++; end
        chk("s6_write_seen", {31'b0, drp_dwe}, 1);
        @(posedge clk); #3 rst_n = 0;
        #1 chk_reset_vals("s6_rst");
        repeat (4) @(negedge clk);
        @(posedge clk); #2 rst_n = 1;
        rsp_lat = 2;
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; rr0 = n_rst_rise;
        send(7'h09, 16'h0000, 16'h7777, 1, 1);
        wait_end(400);
        chk("s6_done", {31'b0, done}, 1);
        seq_checks("s6", rd0, wr0, dn0, rr0, 1, 1, 1);
        chk("s6_mem", {16'b0, pll_mem[9]}, 32'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_drp_reconfig.md
Name: pll_drp_reconfig

Overview:
DRP initiator that dynamically reprograms a PLLE2/MMCM-style PLL through its DRP port. The PLL model exposes the responder side of DRP (DADDR/DEN/DWE/DI/DO/DRDY) and has it tied off in the base wrapper. This block accepts a stream of register updates, performs a read-modify-write for each one while holding the PLL in reset, then releases reset and waits for LOCKED. It sits between the clocking CSR logic and the PLL_ADV-class instance.

Parameters:
RST_HOLD, 4, cycles pll_rst is held asserted before the first DRP access (min 1)
DRDY_TIMEOUT, 64, max cycles waiting for drp_drdy after a DEN strobe
LOCK_TIMEOUT, 65535, max cycles waiting for pll_locked after reset release
CNT_W, 16, width of the shared timeout/hold counter; must hold max(RST_HOLD, DRDY_TIMEOUT, LOCK_TIMEOUT)

Ports:
clk  in  1  DRP clock; also drives the PLL DCLK
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  update entry valid
cmd_ready  out  1  entry accepted when valid&ready
cmd_addr  in  7  DRP register address
cmd_mask  in  16  1 = keep the existing bit, 0 = replace it with cmd_data
cmd_data  in  16  new bit values
cmd_last  in  1  final entry of the sequence
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful lock
error  out  1  sticky; cleared when the next sequence is accepted
err_code  out  2  0 none, 1 DRDY timeout, 2 lock timeout
drp_daddr  out  7  to PLL DADDR
drp_den  out  1  to PLL DEN; single-cycle strobe
drp_dwe  out  1  to PLL DWE
drp_di  out  16  to PLL DI
drp_do  in  16  from PLL DO
drp_drdy  in  1  from PLL DRDY
pll_rst  out  1  to PLL RST
pll_locked  in  1  from PLL LOCKED

Behaviour:
- Reset values:
  - cmd_ready=1; busy, done, error, drp_den, drp_dwe, pll_rst = 0.
  - err_code=0; drp_daddr and drp_di = 0.
  - State = IDLE; all internal counters and registers cleared.
- All outputs are registered.
- IDLE:
  - cmd_ready=1. On accept, latch addr/mask/data/last, clear error and err_code, set pll_rst=1, load the counter, then go to HOLD.
- HOLD:
  - Hold for RST_HOLD cycles, then go to READ.
- READ:
  - Drive drp_den=1, drp_dwe=0, drp_daddr=addr for exactly one cycle, load the counter, then go to WAIT_RD.
- WAIT_RD:
  - On drp_drdy, compute wr = (drp_do & mask) | (cmd_data & ~mask) and go to WRITE.
  - If DRDY_TIMEOUT cycles pass with no drdy, go to ABORT with code 1.
- WRITE:
  - Drive drp_den=1, drp_dwe=1, drp_daddr=addr, drp_di=wr for one cycle, then go to WAIT_WR.
- WAIT_WR:
  - On drp_drdy, go to RELEASE if last, else to NEXT.
  - On timeout, go to ABORT with code 1.
- NEXT:
  - cmd_ready=1 while pll_rst stays 1. Wait indefinitely; on accept, latch the entry and go to READ.
- RELEASE:
  - pll_rst=0, load the counter, then go to WAIT_LOCK.
- WAIT_LOCK:
  - When pll_locked=1, go to DONE.
  - After LOCK_TIMEOUT cycles, set error=1, err_code=2, and go to IDLE.
- DONE:
  - done=1 for one cycle, then go to IDLE.
- ABORT:
  - error=1, err_code=1, pll_rst=0, then go to IDLE. The PLL is left as partially written.
- cmd_ready is 0 in every state except IDLE and NEXT.
- drp_den is never asserted on two consecutive cycles. At most one DRP transaction is outstanding at any time.
- drp_drdy is honoured only in WAIT_RD and WAIT_WR; any drdy seen elsewhere is ignored. drdy is not sampled in the same cycle as den, so the earliest valid response is one cycle after the strobe.
- A drdy arriving in the same cycle as the timeout expiry counts as success.
- pll_locked is ignored outside WAIT_LOCK. A LOCKED that is still stale-high during HOLD has no effect.
- Counters saturate and do not wrap.
- rst_n asserted mid-sequence: all outputs take their reset values immediately, including pll_rst=0. No DRP strobe is issued after reset.

Test Plan:
- Single entry, addr=0x08, mask=0x1000, data=0x0041, PLL returns do=0xF3C7 after 2 cycles → write di=0x1041 to addr 0x08. Sequence is pll_rst high for RST_HOLD+, one read, one write, pll_rst low, then done pulse when locked rises; error=0.
- Three entries (0x08, 0x09, 0x14, last on third) with cmd_valid dropped for 10 cycles between entries → exactly 3 reads and 3 writes in address order, pll_rst held continuously high across the gap, cmd_ready low during each access.
- PLL never asserts drdy on the read of 0x14 → 64 cycles after DEN: error=1, err_code=1, pll_rst=0, back in IDLE, no write issued.
- pll_locked held low after release → after 65535 cycles: error=1, err_code=2, done never pulses. The next accepted cmd clears error.
- Spurious drdy in IDLE and HOLD, and pll_locked=1 during HOLD → no state change, sequence completes normally.
- rst_n pulsed low during WAIT_WR → all outputs at reset values asynchronously; after release, a new sequence completes correctly.
